// File: rtl/mem_bus_ctrl_if.sv
// Data-bus request/response types and the handshake bundle between the memory
// stage, mem_bus_ctrl and the data bus.
//
// Package mem_bus_ctrl_pkg:
//   msize_t      access size encoding
//   dbus_req_t   valid, addr, size, strobe, data
//   dbus_resp_t  addr_ok, data_ok, data
//
// Interface mem_bus_ctrl_if:
//   in_req     request built by the memory stage
//   advance    M->W register captures this cycle
//   flush      instruction in M is killed this cycle
//   dresp      response from the data bus
//   dreq       request driven to the data bus
//   mem_stall  M stage must hold
//   rdata      loaded word
//   modport slave  : the controller's view
//   modport master : the pipeline/bus environment's view

package mem_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

interface mem_bus_ctrl_if;
  import mem_bus_ctrl_pkg::*;

  dbus_req_t   in_req;
  logic        advance;
  logic        flush;
  dbus_resp_t  dresp;
  dbus_req_t   dreq;
  logic        mem_stall;
  logic [31:0] rdata;

  modport slave (
    input  in_req,
    input  advance,
    input  flush,
    input  dresp,
    output dreq,
    output mem_stall,
    output rdata
  );

  modport master (
    output in_req,
    output advance,
    output flush,
    output dresp,
    input  dreq,
    input  mem_stall,
    input  rdata
  );

endinterface

// File: rtl/mem_bus_ctrl.sv
// Data-bus handshake controller sitting after the memory stage.
//
// Issues the memory stage's request on the data bus under the addr_ok/data_ok
// protocol, holds it stable until accepted, captures the response word when
// the pipeline cannot take it yet, raises mem_stall for the hazard unit and
// drains an outstanding transaction when the instruction in M is flushed.
//
// Ports:
//   clk     single clock
//   resetn  asynchronous active-low reset
//   bus     mem_bus_ctrl_if.slave: in_req, advance, flush, dresp (in);
//           dreq, mem_stall, rdata (out)

module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
(
  input logic           clk,
  input logic           resetn,
  mem_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StDone,
    StDrainA,
    StDrainD
  } state_e;

  state_e      state_q, state_d;
  dbus_req_t   req_buf_q, req_buf_d;
  logic [31:0] data_buf_q, data_buf_d;

  logic issue;     // a new request goes out from IDLE this cycle
  logic both_ok;   // address and data phase both finish this cycle
  logic complete;  // data phase finishes this cycle
  logic in_flight; // state in which the M instruction may be waiting on the bus
  logic draining;

  assign issue    = bus.in_req.valid & ~bus.flush;
  assign both_ok  = bus.dresp.addr_ok & bus.dresp.data_ok;
  assign draining = (state_q == StDrainA) | (state_q == StDrainD);
  assign in_flight = (state_q == StIdle) | (state_q == StAddr) | (state_q == StData);

  // Next-state logic. flush takes priority over advance.
  always_comb begin
    state_d    = state_q;
    req_buf_d  = req_buf_q;
    data_buf_d = data_buf_q;
    complete   = 1'b0;

    case (state_q)
      StIdle: begin
        if (issue) begin
          req_buf_d = bus.in_req;
          complete  = both_ok;
          if (both_ok) begin
            if (bus.advance) begin
              state_d = StIdle;
            end else begin
              state_d    = StDone;
              data_buf_d = bus.dresp.data;
            end
          end else if (bus.dresp.addr_ok) begin
            state_d = StData;
          end else begin
            state_d = StAddr;
          end
        end
      end

      StAddr: begin
        complete = both_ok;
        if (bus.flush) begin
          // The request stays on the bus until accepted; its response is
          // then swallowed in the drain states.
          if (both_ok) begin
            state_d = StIdle;
          end else if (bus.dresp.addr_ok) begin
            state_d = StDrainD;
          end else begin
            state_d = StDrainA;
          end
        end else if (both_ok) begin
          if (bus.advance) begin
            state_d = StIdle;
          end else begin
            state_d    = StDone;
            data_buf_d = bus.dresp.data;
          end
        end else if (bus.dresp.addr_ok) begin
          state_d = StData;
        end
      end

      StData: begin
        complete = bus.dresp.data_ok;
        if (bus.dresp.data_ok) begin
          if (bus.flush || bus.advance) begin
            state_d = StIdle;
          end else begin
            state_d    = StDone;
            data_buf_d = bus.dresp.data;
          end
        end else if (bus.flush) begin
          state_d = StDrainD;
        end
      end

      StDone: begin
        if (bus.flush || bus.advance) begin
          state_d = StIdle;
        end
      end

      StDrainA: begin
        if (both_ok) begin
          state_d = StIdle;
        end else if (bus.dresp.addr_ok) begin
          state_d = StDrainD;
        end
      end

      StDrainD: begin
        if (bus.dresp.data_ok) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      req_buf_q  <= '0;
      data_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      req_buf_q  <= req_buf_d;
      data_buf_q <= data_buf_d;
    end
  end

  // Bus request source. resetn gates valid so nothing is presented while
  // reset is held, whatever the memory stage is driving.
  always_comb begin
    bus.dreq = req_buf_q;
    case (state_q)
      StIdle: begin
        bus.dreq       = bus.in_req;
        bus.dreq.valid = issue;
      end
      StAddr, StDrainA: begin
        bus.dreq.valid = 1'b1;
      end
      default: begin
        bus.dreq.valid = 1'b0;
      end
    endcase
    bus.dreq.valid = bus.dreq.valid & resetn;
  end

  always_comb begin
    bus.mem_stall = resetn & ((issue & in_flight & ~complete) | draining);
  end

  always_comb begin
    bus.rdata = (state_q == StDone) ? data_buf_q : bus.dresp.data;
  end

  // Bus protocol: an unaccepted request is neither withdrawn nor altered.
  a_req_held: assert property (@(posedge clk) disable iff (!resetn)
    (bus.dreq.valid && !bus.dresp.addr_ok) |=>
      (bus.dreq.valid && $stable(bus.dreq.addr) && $stable(bus.dreq.size) &&
       $stable(bus.dreq.strobe) && $stable(bus.dreq.data)));

  // The hazard unit must never advance a stalled M stage.
  a_no_advance_on_stall: assert property (@(posedge clk) disable iff (!resetn)
    bus.advance |-> !bus.mem_stall);

endmodule
